exec_writeback_stage: RTL and testbench
=======================================

# exec_writeback_stage

Downstream stage of the 8-bit ALU. It takes the ALU's result, its flags and its condition decision, then commits architectural state. It owns:
- the 8x8 register file, whose read ports feed ALU A/B;
- the 4-bit CPSR {N,Z,C,V}, which feeds ALU `inst_conds`;
- a 16x8 data memory;
- the 8-bit PC, which feeds ALU `PC`.

Loads take one extra cycle, and the stage signals this with `stall`.

## Interface
Parameters:
- `RF_DEPTH`, 8: register count; address width is fixed at 3 bits.
- `DMEM_DEPTH`, 16: data memory bytes; address is `alu_out[3:0]`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  execute result valid this cycle.
- `control`  in  4  ALU opcode of the instruction being committed.
- `cond_satisfy`  in  1  ALU condition-pass for this instruction.
- `alu_out`  in  8  ALU result, used as data, address or branch target.
- `conditions_flags`  in  4  ALU flags {N,Z,C,V}.
- `cpsr_write`  in  1  ALU flag-update request.
- `rd`  in  3  destination register.
- `store_data`  in  8  STR data.
- `rs1`, `rs2`  in  3  read addresses.
- `rdata1`, `rdata2`  out  8  read data, to ALU A/B.
- `inst_conds`  out  4  CPSR, to ALU.
- `pc`  out  8  program counter.
- `stall`  out  1  stage busy; upstream must hold its inputs.

## Operation
**Acceptance.** An instruction is accepted when `in_valid && !stall`. It is committed only if `cond_satisfy=1`; otherwise it is accepted with no state change except PC+4.

**Opcode actions** (when accepted and committed):
- 0011 ADD, 0010 SUB, 0000 AND, 0001 XOR, 0110 MOV: `rf[rd] <= alu_out`.
- 0100 CMP, 0101 CMN: no register write.
- 1001 STR: `dmem[alu_out[3:0]] <= store_data`. Address bits [7:4] are ignored, so the address wraps.
- 1000 LDR: latch `alu_out[3:0]` and `rd`, then go to state LOAD.
- 0111 B, 1010 BEQ, 1011 BNE: `pc <= alu_out`. For BEQ/BNE the ALU has already selected target or PC+4.
- 1100-1111: no effect other than PC+4.

**PC.**
- All non-branch accepted instructions, and any accepted instruction with `cond_satisfy=0`: `pc <= pc + 4`, modulo 256.
- No accepted instruction: `pc` holds.

**CPSR.** `inst_conds <= conditions_flags` when accepted, `cond_satisfy=1` and `cpsr_write=1`. Otherwise it holds.

**Register reads.** Combinational `rdata = rf[rs]`, with write-through bypass. If a register write is occurring this cycle to the same address, the read returns the data being written (either `alu_out` or the load data).

**FSM.**
- IDLE: `stall=0`. An accepted, committed LDR moves to LOAD.
- LOAD: `stall=1`. Read `dmem[latched_addr]` combinationally, write it to `rf[latched_rd]` at the edge, then return to IDLE. `in_valid` is ignored in this state.

**Reset.** Every `rf` entry is 0, the CPSR is 0000, `pc` is 0x00, the FSM is IDLE and `stall` is 0. Data memory is not reset.
- If reset occurs in LOAD, the load is abandoned and there is no register write.
- Reset has priority over all writes.

## Timing
- Reset values of outputs: `rdata1`/`rdata2` = 0, `inst_conds` = 0000, `pc` = 0x00, `stall` = 0.
- ALU ops, MOV, CMP, STR and branches: single cycle. The result is visible in `rf`, CPSR, dmem and `pc` after the accepting edge.
- LDR:
  - Edge 0 accepts the load and advances `pc`.
  - Cycle 1 has `stall=1`.
  - Edge 1 writes `rf`.
  - Cycle 2 has `stall=0`, and a new instruction may be accepted.
  - Load-use throughput is 1 instruction per 2 cycles.
- STR immediately followed by LDR to the same address: the load returns the stored value.
- A register write and a read of the same address in the same cycle return the new value via bypass.
- `pc` at 0xFC + 4 wraps to 0x00.
- `rd = 0` is writable; there is no hard-wired zero register.

## Test plan
- Reset, then ADD with `alu_out=0x2A`, `rd=3`, committed, `cpsr_write=1`, flags 0100 -> next cycle `rf[3]=0x2A`, `inst_conds=0100`, `pc=0x04`.
- ADD with `cond_satisfy=0`, `rd=5`, `alu_out=0x11` -> `rf[5]` unchanged, CPSR unchanged, `pc` += 4.
- STR with `alu_out=0x37`, `store_data=0x9C`, then LDR with `alu_out=0x07`, `rd=2` -> `stall=1` for exactly one cycle, then `rf[2]=0x9C`; `pc` advances 8 in total.
- BEQ with `alu_out=0x40` and `cond_satisfy=1` -> `pc=0x40`, no register or CPSR write. Separately, `pc=0xFC` with a non-branch -> `pc=0x00`.
- Write `rd=4` with `0x55` while `rs1=4` -> `rdata1=0x55` in the same cycle.
- LDR accepted, then `reset` asserted during the stall cycle -> no rf write, `stall=0`, `pc=0x00`, `rf[*]=0`.

Source files
------------

// File: rtl/exec_writeback_stage.sv
// Execute/writeback stage: commits ALU results into the register file, CPSR,
// data memory and PC. Loads take one extra cycle (LOAD state, stall high).
// Handshake: an instruction is accepted on a rising edge where in_valid=1 and
// stall=0; while stall=1 upstream holds its inputs and in_valid is ignored.
module exec_writeback_stage #(
  parameter int RF_DEPTH   = 8,
  parameter int DMEM_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] control,
  input  logic       cond_satisfy,
  input  logic [7:0] alu_out,
  input  logic [3:0] conditions_flags,
  input  logic       cpsr_write,
  input  logic [2:0] rd,
  input  logic [7:0] store_data,
  input  logic [2:0] rs1,
  input  logic [2:0] rs2,
  output logic [7:0] rdata1,
  output logic [7:0] rdata2,
  output logic [3:0] inst_conds,
  output logic [7:0] pc,
  output logic       stall,
  output logic       dbg_state
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_XOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_MOV = 4'b0110;
  localparam logic [3:0] OP_B   = 4'b0111;
  localparam logic [3:0] OP_LDR = 4'b1000;
  localparam logic [3:0] OP_STR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1011;

  typedef enum logic {S_IDLE = 1'b0, S_LOAD = 1'b1} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_rf   [RF_DEPTH];
  logic [7:0]  r_dmem [DMEM_DEPTH];
  logic [7:0]  r_pc;
  logic [3:0]  r_cpsr;
  logic [3:0]  r_ld_addr;
  logic [2:0]  r_ld_rd;

  logic        w_accept;
  logic        w_commit;
  logic        w_rf_op;
  logic        w_branch;
  logic        w_is_str;
  logic        w_is_ldr;
  logic        w_load_wr;
  logic        w_wr_en;
  logic [2:0]  w_wr_addr;
  logic [7:0]  w_wr_data;

  // Opcode decode into the few action classes the stage cares about
  always_comb begin
    w_rf_op  = 1'b0;
    w_branch = 1'b0;
    w_is_str = 1'b0;
    w_is_ldr = 1'b0;
    case (control)
      OP_AND, OP_XOR, OP_SUB, OP_ADD, OP_MOV: w_rf_op  = 1'b1;
      OP_B, OP_BEQ, OP_BNE:                   w_branch = 1'b1;
      OP_STR:                                 w_is_str = 1'b1;
      OP_LDR:                                 w_is_ldr = 1'b1;
      default: ;
    endcase
  end

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_commit  = w_accept && cond_satisfy;
  assign w_load_wr = (r_state == S_LOAD);

  // Single register-file write port shared by ALU results and load returns;
  // the two sources never coincide because LOAD blocks acceptance.
  assign w_wr_en   = !reset && (w_load_wr || (w_commit && w_rf_op));
  assign w_wr_addr = w_load_wr ? r_ld_rd : rd;
  assign w_wr_data = w_load_wr ? r_dmem[r_ld_addr] : alu_out;

  // Read ports with write-through bypass of the value being written this cycle
  always_comb begin
    rdata1 = r_rf[rs1];
    rdata2 = r_rf[rs2];
    if (w_wr_en && (w_wr_addr == rs1)) rdata1 = w_wr_data;
    if (w_wr_en && (w_wr_addr == rs2)) rdata2 = w_wr_data;
  end

  // Register file storage; reset clears every entry
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RF_DEPTH; i++) r_rf[i] <= '0;
    end else if (w_wr_en) begin
      r_rf[w_wr_addr] <= w_wr_data;
    end
  end

  // Data memory: no reset, stores address with the low nibble only (wraps)
  always_ff @(posedge clk) begin
    if (!reset && w_commit && w_is_str) r_dmem[alu_out[3:0]] <= store_data;
  end

  // PC, CPSR and pending-load bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= 8'h00;
      r_cpsr    <= 4'h0;
      r_ld_addr <= 4'h0;
      r_ld_rd   <= 3'h0;
    end else if (w_accept) begin
      r_pc <= (w_commit && w_branch) ? alu_out : r_pc + 8'd4;
      if (w_commit && cpsr_write) r_cpsr <= conditions_flags;
      if (w_commit && w_is_ldr) begin
        r_ld_addr <= alu_out[3:0];
        r_ld_rd   <= rd;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next state and stall output
  always_comb begin
    w_next_state = r_state;
    stall        = 1'b0;
    case (r_state)
      S_IDLE: if (w_commit && w_is_ldr) w_next_state = S_LOAD;
      S_LOAD: begin
        stall        = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign inst_conds = r_cpsr;
  assign pc         = r_pc;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_exec_writeback_stage.sv
// Bench for exec_writeback_stage: directed scenarios followed by random
// instruction streams, checked against an architectural model of the stage.
module tb_exec_writeback_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] control = '0;
  logic       cond_satisfy = 1'b0;
  logic [7:0] alu_out = '0;
  logic [3:0] conditions_flags = '0;
  logic       cpsr_write = 1'b0;
  logic [2:0] rd = '0;
  logic [7:0] store_data = '0;
  logic [2:0] rs1 = '0;
  logic [2:0] rs2 = '0;
  logic [7:0] rdata1, rdata2, pc;
  logic [3:0] inst_conds;
  logic       stall, dbg_state;

  exec_writeback_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .control(control),
    .cond_satisfy(cond_satisfy), .alu_out(alu_out),
    .conditions_flags(conditions_flags), .cpsr_write(cpsr_write), .rd(rd),
    .store_data(store_data), .rs1(rs1), .rs2(rs2), .rdata1(rdata1),
    .rdata2(rdata2), .inst_conds(inst_conds), .pc(pc), .stall(stall),
    .dbg_state(dbg_state)
  );

  // ---------------- architectural model ----------------
  logic [7:0] m_rf [8];
  logic [7:0] m_dmem [16];
  logic [7:0] m_pc;
  logic [3:0] m_cpsr;
  bit         m_pending;
  logic [3:0] m_ld_addr;
  logic [2:0] m_ld_rd;
  bit [15:0]  m_dmem_known;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit writes_rf(input logic [3:0] op);
    return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) || (op == 4'd3) || (op == 4'd6);
  endfunction

  function automatic bit is_branch(input logic [3:0] op);
    return (op == 4'd7) || (op == 4'd10) || (op == 4'd11);
  endfunction

  // Value a read port should show right now, given what is being committed
  function automatic logic [7:0] exp_read(input logic [2:0] a);
    if (reset) return m_rf[a];
    if (m_pending) return (m_ld_rd == a) ? m_dmem[m_ld_addr] : m_rf[a];
    if (in_valid && cond_satisfy && writes_rf(control) && rd == a) return alu_out;
    return m_rf[a];
  endfunction

  // Architectural effect of one rising edge
  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
      m_cpsr = 4'h0;
      m_pc = 8'h00;
      m_pending = 1'b0;
    end else if (m_pending) begin
      m_rf[m_ld_rd] = m_dmem[m_ld_addr];
      m_pending = 1'b0;
    end else if (in_valid) begin
      if (cond_satisfy) begin
        if (writes_rf(control)) m_rf[rd] = alu_out;
        if (control == 4'd9) begin
          m_dmem[alu_out[3:0]] = store_data;
          m_dmem_known[alu_out[3:0]] = 1'b1;
        end
        if (control == 4'd8) begin
          m_pending = 1'b1;
          m_ld_addr = alu_out[3:0];
          m_ld_rd = rd;
        end
        if (cpsr_write) m_cpsr = conditions_flags;
      end
      m_pc = (cond_satisfy && is_branch(control)) ? alu_out : m_pc + 8'd4;
    end
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit rst, input bit v, input logic [3:0] op, input bit cs,
                      input logic [7:0] a, input logic [3:0] f, input bit cw,
                      input logic [2:0] d, input logic [7:0] sd,
                      input logic [2:0] r1, input logic [2:0] r2);
    @(negedge clk);
    reset = rst; in_valid = v; control = op; cond_satisfy = cs; alu_out = a;
    conditions_flags = f; cpsr_write = cw; rd = d; store_data = sd; rs1 = r1; rs2 = r2;
    #1;
    chk("rdata1_pre", rdata1, exp_read(r1));
    chk("rdata2_pre", rdata2, exp_read(r2));
    chk("stall_pre", {7'd0, stall}, {7'd0, m_pending});
    @(posedge clk);
    model_edge();
    #1;
    chk("pc", pc, m_pc);
    chk("cpsr", {4'd0, inst_conds}, {4'd0, m_cpsr});
    chk("stall", {7'd0, stall}, {7'd0, m_pending});
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
  endtask

  // Compare every register through both read ports
  task automatic dump_rf();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rs1 = 3'(i);
      rs2 = 3'(i + 4);
      #1;
      chk("rf_dump1", rdata1, exp_read(3'(i)));
      chk("rf_dump2", rdata2, exp_read(3'(i + 4)));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] op;
    logic [7:0] a;
    for (int i = 0; i < 8; i++) m_rf[i] = 8'hxx;
    m_pc = 8'hxx; m_cpsr = 4'hx; m_pending = 1'b0; m_dmem_known = '0;
    m_ld_addr = '0; m_ld_rd = '0;
    for (int i = 0; i < 16; i++) m_dmem[i] = 8'hxx;

    // reset
    step(1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    step(1'b1, 1'b1, 4'd3, 1'b1, 8'hAA, 4'hF, 1'b1, 3'd1, 8'h00, 3'd1, 3'd2);
    chk("reset_pc", pc, 8'h00);
    chk("reset_stall", {7'd0, stall}, 8'h00);
    dump_rf();

    // ADD committed with flag update
    step(1'b0, 1'b1, 4'd3, 1'b1, 8'h2A, 4'b0100, 1'b1, 3'd3, 8'h00, 3'd3, 3'd0);
    chk("add_pc", pc, 8'h04);
    chk("add_cpsr", {4'd0, inst_conds}, 8'h04);
    dump_rf();

    // ADD not committed: only PC moves
    step(1'b0, 1'b1, 4'd3, 1'b0, 8'h11, 4'hF, 1'b1, 3'd5, 8'h00, 3'd5, 3'd3);
    chk("nocommit_pc", pc, 8'h08);
    dump_rf();

    // STR then LDR same address (wrapped), one stall cycle, ignored input
    step(1'b0, 1'b1, 4'd9, 1'b1, 8'h37, 4'h0, 1'b0, 3'd0, 8'h9C, 3'd0, 3'd1);
    step(1'b0, 1'b1, 4'd8, 1'b1, 8'h07, 4'h0, 1'b0, 3'd2, 8'h00, 3'd2, 3'd3);
    chk("ldr_stall", {7'd0, stall}, 8'h01);
    step(1'b0, 1'b1, 4'd6, 1'b1, 8'hFF, 4'hF, 1'b1, 3'd2, 8'h00, 3'd2, 3'd4);
    chk("ldr_stall_done", {7'd0, stall}, 8'h00);
    chk("ldr_pc", pc, 8'h10);
    dump_rf();

    // BEQ taken, then branch to 0xFC and a non-branch wraps PC
    step(1'b0, 1'b1, 4'd10, 1'b1, 8'h40, 4'hF, 1'b0, 3'd6, 8'h00, 3'd6, 3'd0);
    chk("beq_pc", pc, 8'h40);
    step(1'b0, 1'b1, 4'd7, 1'b1, 8'hFC, 4'h0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    step(1'b0, 1'b1, 4'd0, 1'b1, 8'h12, 4'h0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd7);
    chk("wrap_pc", pc, 8'h00);

    // Same-cycle bypass of rd=4
    step(1'b0, 1'b1, 4'd6, 1'b1, 8'h55, 4'h0, 1'b0, 3'd4, 8'h00, 3'd4, 3'd4);
    dump_rf();

    // Fill data memory so random loads always read known bytes
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, 4'd9, 1'b1, {4'($urandom_range(0, 15)), 4'(i)}, 4'h0, 1'b0,
           3'd0, 8'($urandom), 3'($urandom), 3'($urandom));

    // Random instruction stream
    for (int n = 0; n < 400; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom);
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), op,
           ($urandom_range(0, 3) != 0), a, 4'($urandom), 1'($urandom),
           3'($urandom), 8'($urandom), 3'($urandom), 3'($urandom));
      if (n % 50 == 0) dump_rf();
    end

    // Reset during the load stall abandons the load
    step(1'b0, 1'b1, 4'd3, 1'b1, 8'h77, 4'h0, 1'b0, 3'd1, 8'h00, 3'd1, 3'd0);
    step(1'b0, 1'b1, 4'd8, 1'b1, 8'h03, 4'h0, 1'b0, 3'd1, 8'h00, 3'd1, 3'd0);
    step(1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd0);
    chk("rst_load_stall", {7'd0, stall}, 8'h00);
    chk("rst_load_pc", pc, 8'h00);
    idle_step();
    dump_rf();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
